// File: rtl/bs_arb.sv
// rtl/bs_arb.sv - round-robin arbiter sharing one pipelined barrel shifter among N requesters
// bs is the shared shifter; bs_arb wraps it with arbitration and a 2-stage pipeline.

module bs #(
    parameter int W       = 32,
    parameter int SHIFT_W = $clog2(W),
    parameter bit INFER   = 1'b0
) (
    input  logic [W-1:0]       x,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               is_arith,
    input  logic               is_rotate,
    input  logic               is_right,
    output logic [W-1:0]       y
);

    generate
        if (INFER) begin : g_infer
            logic [2*W-1:0] rot_r;
            logic [2*W-1:0] rot_l;

            assign rot_r = {x, x} >> shift;
            assign rot_l = {x, x} << shift;

            always_comb begin
                y = '0;
                if (is_rotate) begin
                    y = is_right ? rot_r[W-1:0] : rot_l[2*W-1:W];
                end else if (is_right) begin
                    y = is_arith ? W'($signed(x) >>> shift) : (x >> shift);
                end else begin
                    y = x << shift;
                end
            end
        end else begin : g_stages
            // Left operations are right operations on the bit-reversed word.
            function automatic logic [W-1:0] rev(input logic [W-1:0] v);
                logic [W-1:0] r;
                r = '0;
                for (int i = 0; i < W; i++) begin
                    r[i] = v[W-1-i];
                end
                return r;
            endfunction

            logic [W-1:0] st [0:SHIFT_W];
            logic         fill;

            assign fill  = is_arith & is_right & ~is_rotate & x[W-1];
            assign st[0] = is_right ? x : rev(x);

            for (genvar k = 0; k < SHIFT_W; k++) begin : g_lvl
                localparam int D = 1 << k;
                logic [D-1:0] top;

                assign top       = is_rotate ? st[k][D-1:0] : {D{fill}};
                assign st[k+1]   = shift[k] ? {top, st[k][W-1:D]} : st[k];
            end

            assign y = is_right ? st[SHIFT_W] : rev(st[SHIFT_W]);
        end
    endgenerate

endmodule

module bs_arb #(
    parameter int W       = 32,
    parameter int SHIFT_W = $clog2(W),
    parameter int N       = 4,
    parameter int ID_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [N-1:0]                req_vld_i,
    output logic [N-1:0]                req_rdy_o,
    input  logic [N-1:0][W-1:0]         req_x_i,
    input  logic [N-1:0][SHIFT_W-1:0]   req_shift_i,
    input  logic [N-1:0]                req_is_arith_i,
    input  logic [N-1:0]                req_is_rotate_i,
    input  logic [N-1:0]                req_is_right_i,
    output logic                        rsp_vld_o,
    input  logic                        rsp_rdy_i,
    output logic [ID_W-1:0]             rsp_id_o,
    output logic [W-1:0]                rsp_y_o,
    output logic                        busy_o
);

    logic               s1_vld;
    logic [W-1:0]       s1_x;
    logic [SHIFT_W-1:0] s1_shift;
    logic               s1_arith;
    logic               s1_rotate;
    logic               s1_right;
    logic [ID_W-1:0]    s1_id;

    logic               s2_vld;
    logic [W-1:0]       s2_y;
    logic [ID_W-1:0]    s2_id;

    logic [ID_W-1:0]    rr_ptr;
    logic               s2_adv;
    logic               s1_adv;
    logic               any_vld;
    logic               grant;
    logic [ID_W-1:0]    grant_idx;
    logic [W-1:0]       bs_y;

    assign s2_adv = ~s2_vld | rsp_rdy_i;
    assign s1_adv = ~s1_vld | s2_adv;

    // First valid requester at or above rr_ptr, wrapping modulo N.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        any_vld   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = ID_W'(idx);
            if (!any_vld && req_vld_i[cand]) begin
                any_vld   = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant = s1_adv & any_vld;

    always_comb begin
        req_rdy_o = '0;
        if (grant) begin
            req_rdy_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_vld    <= 1'b0;
            s1_x      <= '0;
            s1_shift  <= '0;
            s1_arith  <= 1'b0;
            s1_rotate <= 1'b0;
            s1_right  <= 1'b0;
            s1_id     <= '0;
        end else if (grant) begin
            s1_vld    <= 1'b1;
            s1_x      <= req_x_i[grant_idx];
            s1_shift  <= req_shift_i[grant_idx];
            s1_arith  <= req_is_arith_i[grant_idx];
            s1_rotate <= req_is_rotate_i[grant_idx];
            s1_right  <= req_is_right_i[grant_idx];
            s1_id     <= grant_idx;
        end else if (s2_adv) begin
            s1_vld    <= 1'b0;
        end
    end

    bs #(
        .W       (W),
        .SHIFT_W (SHIFT_W),
        .INFER   (1'b0)
    ) u_bs (
        .x         (s1_x),
        .shift     (s1_shift),
        .is_arith  (s1_arith),
        .is_rotate (s1_rotate),
        .is_right  (s1_right),
        .y         (bs_y)
    );

    // Stage-2 data only moves when a real command arrives, so a stalled response stays frozen.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s2_vld <= 1'b0;
            s2_y   <= '0;
            s2_id  <= '0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_y  <= bs_y;
                s2_id <= s1_id;
            end
        end
    end

    assign rsp_vld_o = s2_vld;
    assign rsp_y_o   = s2_y;
    assign rsp_id_o  = s2_id;
    assign busy_o    = s1_vld | s2_vld;

endmodule

// File: tb/tb_bs_arb.sv
// tb/tb_bs_arb.sv - directed self-checking bench for bs_arb
module tb_bs_arb;

    localparam int W       = 32;
    localparam int SHIFT_W = 5;
    localparam int N       = 4;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      arst;
    logic [N-1:0]              req_vld;
    logic [N-1:0]              req_rdy;
    logic [N-1:0][W-1:0]       req_x;
    logic [N-1:0][SHIFT_W-1:0] req_shift;
    logic [N-1:0]              req_arith;
    logic [N-1:0]              req_rotate;
    logic [N-1:0]              req_right;
    logic                      rsp_vld;
    logic                      rsp_rdy;
    logic [ID_W-1:0]           rsp_id;
    logic [W-1:0]              rsp_y;
    logic                      busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0;

    int          acc_q[$];
    logic [31:0] y_q[$];
    int          id_q[$];
    int          rc_q[$];

    bs_arb #(.W(W), .SHIFT_W(SHIFT_W), .N(N), .ID_W(ID_W)) dut (
        .clk             (clk),
        .arst            (arst),
        .req_vld_i       (req_vld),
        .req_rdy_o       (req_rdy),
        .req_x_i         (req_x),
        .req_shift_i     (req_shift),
        .req_is_arith_i  (req_arith),
        .req_is_rotate_i (req_rotate),
        .req_is_right_i  (req_right),
        .rsp_vld_o       (rsp_vld),
        .rsp_rdy_i       (rsp_rdy),
        .rsp_id_o        (rsp_id),
        .rsp_y_o         (rsp_y),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!arst) begin
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && req_rdy[i]) acc_q.push_back(i);
            end
            if (rsp_vld && rsp_rdy) begin
                y_q.push_back(rsp_y);
                id_q.push_back(int'(rsp_id));
                rc_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put_req(input int i, input logic [31:0] x, input logic [4:0] sh,
                           input logic ar, input logic ro, input logic ri);
        req_x[i]      = x;
        req_shift[i]  = sh;
        req_arith[i]  = ar;
        req_rotate[i] = ro;
        req_right[i]  = ri;
        req_vld[i]    = 1'b1;
    endtask

    task automatic check_rsp(input string tag, input int k, input logic [31:0] ey, input int eid);
        if (k < y_q.size()) begin
            check({tag, "_y"}, y_q[k], ey);
            check({tag, "_id"}, id_q[k], eid);
        end else begin
            check({tag, "_missing"}, y_q.size(), k + 1);
        end
    endtask

    task automatic clear_q();
        acc_q.delete();
        y_q.delete();
        id_q.delete();
        rc_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst       = 1'b1;
        rsp_rdy    = 1'b1;
        req_vld    = '0;
        req_x      = '0;
        req_shift  = '0;
        req_arith  = '0;
        req_rotate = '0;
        req_right  = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_id", rsp_id, 0);
        arst = 1'b0;

        // single arithmetic right shift from req0
        tick();
        put_req(0, 32'h8000_0001, 5'd4, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_rdy", req_rdy, 4'b0001);
        tick();
        req_vld = '0;
        @(negedge clk);
        check("t1_vld_t1", rsp_vld, 0);
        @(negedge clk);
        check("t1_vld_t2", rsp_vld, 1);
        check("t1_y", rsp_y, 32'hF800_0000);
        check("t1_id", rsp_id, 0);

        // rotate-left from req1 and logical right from req2
        tick();
        clear_q();
        put_req(1, 32'h8000_0001, 5'd1, 1'b0, 1'b1, 1'b0);
        put_req(2, 32'h0000_00F0, 5'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("t2_rdy_a", req_rdy, 4'b0010);
        tick();
        req_vld[1] = 1'b0;
        @(negedge clk);
        check("t2_rdy_b", req_rdy, 4'b0100);
        tick();
        req_vld[2] = 1'b0;
        repeat (4) tick();
        check("t2_nrsp", y_q.size(), 2);
        check_rsp("t2_r0", 0, 32'h0000_0003, 1);
        check_rsp("t2_r1", 1, 32'h0000_000F, 2);

        // fairness: all valid for 8 cycles after a reset puts rr_ptr at 0
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        tick();
        clear_q();
        t0 = cyc;
        for (int i = 0; i < N; i++) put_req(i, 32'h1, 5'(i), 1'b0, 1'b0, 1'b0);
        repeat (8) tick();
        req_vld = '0;
        repeat (4) tick();
        check("t3_nacc", acc_q.size(), 8);
        for (int k = 0; k < 8 && k < acc_q.size(); k++) check($sformatf("t3_gnt%0d", k), acc_q[k], k % 4);
        check("t3_nrsp", y_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check_rsp($sformatf("t3_r%0d", k), k, 32'h1 << (k % 4), k % 4);
            if (k < rc_q.size()) check($sformatf("t3_cyc%0d", k), rc_q[k], t0 + 2 + k);
        end

        // response stall with all valid: two accepts, then frozen output
        clear_q();
        rsp_rdy = 1'b0;
        for (int i = 0; i < N; i++) req_vld[i] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check($sformatf("t4_rdy%0d", c), req_rdy, 0);
                check($sformatf("t4_vld%0d", c), rsp_vld, 1);
                check($sformatf("t4_y%0d", c), rsp_y, 32'h1);
                check($sformatf("t4_id%0d", c), rsp_id, 0);
            end
            tick();
        end
        check("t4_nacc_stall", acc_q.size(), 2);
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("t4_rdy_release", req_rdy, 4'b0100);
        check("t4_vld_release", rsp_vld, 1);
        tick();
        req_vld = '0;
        repeat (4) tick();
        check("t4_nacc", acc_q.size(), 3);
        check("t4_nrsp", y_q.size(), 3);
        check_rsp("t4_r0", 0, 32'h1, 0);
        check_rsp("t4_r1", 1, 32'h2, 1);
        check_rsp("t4_r2", 2, 32'h4, 2);

        // reset with two commands in flight
        clear_q();
        rsp_rdy = 1'b0;
        for (int i = 0; i < N; i++) put_req(i, 32'h5555_0000, 5'd3, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        req_vld = '0;
        check("t5_pre_vld", rsp_vld, 1);
        check("t5_pre_nacc", acc_q.size(), 2);
        arst = 1'b1;
        #1;
        check("t5_arst_vld", rsp_vld, 0);
        check("t5_arst_busy", busy, 0);
        clear_q();
        @(negedge clk);
        arst    = 1'b0;
        rsp_rdy = 1'b1;
        tick();
        put_req(2, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b1);
        put_req(3, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_rdy_a", req_rdy, 4'b0100);
        tick();
        req_vld[2] = 1'b0;
        @(negedge clk);
        check("t5_rdy_b", req_rdy, 4'b1000);
        tick();
        req_vld[3] = 1'b0;
        repeat (4) tick();
        check("t5_nrsp", y_q.size(), 2);
        check_rsp("t5_r0", 0, 32'hDEAD_BEEF, 2);
        check_rsp("t5_r1", 1, 32'h8000_0000, 3);
        check("t5_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bs_arb.md
Name: bs_arb

Overview:
- Shares one barrel-shifter datapath (instance of `bs`, INFER=0) between N requesters.
- Each requester issues shift/rotate commands over a valid/ready port. A round-robin arbiter grants one command per cycle into a 2-stage pipeline: command register, then shifter and result register.
- Results return on a single response port tagged with the requester index.
- Sits between the execution-unit issue ports and the shared shifter resource.

Parameters:
- W, 32, data width; power of two, >= 4.
- SHIFT_W, $clog2(W), shift-amount width.
- N, 4, number of requesters; >= 2.
- ID_W, (N > 1) ? $clog2(N) : 1, requester-index width.

Ports:
- clk  input  1  clock; all state on rising edge.
- arst  input  1  asynchronous, active-high reset.
- req_vld_i  input  N  per-requester command valid.
- req_rdy_o  output  N  per-requester command accepted (grant); one-hot or zero.
- req_x_i  input  N x W  per-requester operand.
- req_shift_i  input  N x SHIFT_W  per-requester shift amount.
- req_is_arith_i  input  N  arithmetic right shift.
- req_is_rotate_i  input  N  rotate.
- req_is_right_i  input  N  direction; 1 = right.
- rsp_vld_o  output  1  response valid.
- rsp_rdy_i  input  1  response consumer ready.
- rsp_id_o  output  ID_W  index of the requester that issued the command.
- rsp_y_o  output  W  shifted result.
- busy_o  output  1  OR of stage-1 and stage-2 valid.

Behaviour:
- Reset (arst high, asynchronous):
  - s1_vld, s2_vld = 0; rr_ptr = 0.
  - rsp_vld_o = 0, busy_o = 0, req_rdy_o = 0.
  - rsp_y_o and rsp_id_o = 0 (data registers also reset).
- Reset mid-operation: all in-flight commands are discarded, with no response. Requesters re-present after reset.
- Pipeline advance conditions:
  - s2_adv = ~s2_vld | rsp_rdy_i.
  - s1_adv = ~s1_vld | s2_adv.
  - Stage 1 holds the registered command {x, shift, arith, rotate, right, id}.
  - Stage 2 holds {y, id}. The shifter is driven combinationally from stage 1; its output is captured into stage 2 when s2_adv.
- Arbitration:
  - When s1_adv, the grant goes to the first asserted req_vld_i scanning from rr_ptr upward, modulo N.
  - req_rdy_o[g] = 1 for the winner only, in the same cycle; this is combinational from req_vld_i, rr_ptr and rsp_rdy_i.
  - A transfer occurs when req_vld_i[g] & req_rdy_o[g].
  - On a grant, rr_ptr <= (g + 1) mod N. With no grant, rr_ptr holds.
  - When ~s1_adv, req_rdy_o = 0.
- Handshake rules:
  - A requester must hold valid and payload stable until accepted.
  - req_rdy_o never depends on that requester's payload.
  - rsp_vld_o, rsp_y_o and rsp_id_o are stable while rsp_vld_o & ~rsp_rdy_i.
- Latency and throughput:
  - Accept in cycle T gives rsp_vld_o in cycle T+2 if unstalled.
  - Sustains 1 command per cycle while rsp_rdy_i stays high.
  - Maximum 2 commands in flight. No skid buffer, so req_rdy_o may depend on rsp_rdy_i.
- Stage updates:
  - s1_vld <= grant ? 1 : (s2_adv ? 0 : s1_vld).
  - s2_vld <= s2_adv ? s1_vld : 1.
- Simultaneous events: while full and stalled, rsp_rdy_i rising lets stage 2 drain, stage 1 move to stage 2, and a new grant load stage 1, all in the same cycle.
- Shift semantics: identical to `bs`.
  - Logical left/right zero-fill.
  - Arithmetic right replicates bit W-1; arithmetic left equals logical left.
  - Rotate ignores arith.
  - shift = 0 passes x unchanged.
- Fairness: with all N requesters continuously valid and no stall, each is granted exactly once per N cycles.

Test Plan:
- W=32, N=4; req0 sends x=0x8000_0001, shift=4, arith, right, alone → req_rdy_o=4'b0001 in cycle T; rsp_vld_o at T+2 with y=0xF800_0000, id=0.
- req1 sends rotate-left x=0x8000_0001, shift=1; req2 sends logical-right x=0x0000_00F0, shift=4 → responses y=0x0000_0003 (id 1) then y=0x0000_000F (id 2).
- All 4 requesters continuously valid for 8 cycles, rsp_rdy_i=1 → grant order 0,1,2,3,0,1,2,3; 8 responses in consecutive cycles from T+2.
- rsp_rdy_i=0 for 5 cycles with all requesters valid → exactly 2 accepts, then req_rdy_o=0. rsp_y_o/rsp_id_o stay stable. On rsp_rdy_i=1, a response drains and a new grant occurs the same cycle.
- arst pulsed with 2 commands in flight → rsp_vld_o=0 immediately (asynchronous). After release, rr_ptr=0, and the first grant goes to the lowest-indexed valid requester. No stale response ever appears.
- shift=0 with rotate-right on x=0xDEAD_BEEF, and shift=31 logical-left on x=1 → y=0xDEAD_BEEF and y=0x8000_0000.
